// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// encodings and the register-match helper used by every comparator.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    // Widest register address the match helper accepts; callers size-cast up.
    localparam int REG_AW_MAX = 16;

    // True when a is a real register (not x0) and equals b.
    function automatic logic reg_match(input logic [REG_AW_MAX-1:0] a,
                                       input logic [REG_AW_MAX-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// One-source forwarding comparator: picks the youngest in-flight producer
// of the EX operand, EX/MEM taking priority over MEM/WB.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_regWrite,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_regWrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [REG_AW-1:0] rs,
    output logic [1:0]        sel
);

    // Priority compare: the EX/MEM result is newer, so it shadows MEM/WB.
    always_comb begin
        sel = FWD_NONE;
        if (ex_mem_regWrite && reg_match(REG_AW_MAX'(ex_mem_rd), REG_AW_MAX'(rs))) begin
            sel = FWD_EX_MEM;
        end else if (mem_wb_regWrite && reg_match(REG_AW_MAX'(mem_wb_rd), REG_AW_MAX'(rs))) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: per-source operand forwarding, load-use
// stall, single-entry MDU scoreboard and a saturating stall-cycle counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_memRead,
    input  logic                      ex_mem_regWrite,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      mem_wb_regWrite,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      id_mdu,
    input  logic [REG_AW-1:0]         id_rd,
    output logic [NUM_SRC*2-1:0]      forward,
    output logic                      stall,
    output logic                      bubble,
    output logic                      mdu_busy,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int              SB_CW    = $clog2(MDU_LAT);
    localparam logic [SB_CW-1:0] CNT_LOAD = SB_CW'(MDU_LAT - 1);

    logic              sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0] sb_rd_q,    sb_rd_d;
    logic [SB_CW-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic load_use;
    logic mdu_raw;
    logic mdu_struct;
    logic mdu_pending;
    logic issue;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            fwd_select #(.REG_AW(REG_AW)) u_fwd (
                .ex_mem_regWrite (ex_mem_regWrite),
                .ex_mem_rd       (ex_mem_rd),
                .mem_wb_regWrite (mem_wb_regWrite),
                .mem_wb_rd       (mem_wb_rd),
                .rs              (id_ex_rs[gi*REG_AW +: REG_AW]),
                .sel             (forward[gi*2 +: 2])
            );
        end
    endgenerate

    // Hazard detection; the completion cycle (cnt==0) is not pending because
    // the MDU result is already on MEM/WB and gets forwarded.
    always_comb begin
        mdu_pending = sb_valid_q && (cnt_q != '0);
        load_use    = 1'b0;
        mdu_raw     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_ex_memRead &&
                reg_match(REG_AW_MAX'(id_ex_rd), REG_AW_MAX'(id_rs[i*REG_AW +: REG_AW]))) begin
                load_use = 1'b1;
            end
            if (mdu_pending &&
                reg_match(REG_AW_MAX'(sb_rd_q), REG_AW_MAX'(id_rs[i*REG_AW +: REG_AW]))) begin
                mdu_raw = 1'b1;
            end
        end
        mdu_struct = id_mdu && mdu_pending;
        stall      = load_use || mdu_raw || mdu_struct;
        bubble     = stall;
        issue      = id_mdu && !stall;
    end

    // Scoreboard next state: issue reloads (even in a completion cycle),
    // otherwise count down, and retire the entry on the completion cycle.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_rd_d    = sb_rd_q;
        cnt_d      = cnt_q;
        if (issue) begin
            sb_valid_d = 1'b1;
            sb_rd_d    = id_rd;
            cnt_d      = CNT_LOAD;
        end else if (sb_valid_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end else if (sb_valid_q) begin
            sb_valid_d = 1'b0;
        end
    end

    // Stall counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State registers; reset drops any in-flight MDU entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_q    <= 1'b0;
            sb_rd_q       <= '0;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            sb_valid_q    <= sb_valid_d;
            sb_rd_q       <= sb_rd_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mdu_busy    = sb_valid_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios with
// hand-computed expectations plus randomized traffic against a cycle-time
// model of the scoreboard.
module tb_hazard_forward_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT4_W  = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] id_rs, id_ex_rs;
    logic [REG_AW-1:0]         id_ex_rd, ex_mem_rd, mem_wb_rd, id_rd;
    logic                      id_ex_memRead, ex_mem_regWrite, mem_wb_regWrite, id_mdu;

    logic [NUM_SRC*2-1:0] forward, forward4;
    logic                 stall, bubble, mdu_busy, stall4, bubble4, mdu_busy4;
    logic [CNT_W-1:0]     stall_count;
    logic [CNT4_W-1:0]    stall_count4;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: the MDU entry is described by its issue cycle.
    int cyc;
    bit m_valid;
    int m_issue;
    int m_rd;
    int m_cnt;
    int m_cnt4;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
        .id_ex_memRead(id_ex_memRead), .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
        .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd), .id_mdu(id_mdu), .id_rd(id_rd),
        .forward(forward), .stall(stall), .bubble(bubble), .mdu_busy(mdu_busy),
        .stall_count(stall_count)
    );

    hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .CNT_W(CNT4_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
        .id_ex_memRead(id_ex_memRead), .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
        .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd), .id_mdu(id_mdu), .id_rd(id_rd),
        .forward(forward4), .stall(stall4), .bubble(bubble4), .mdu_busy(mdu_busy4),
        .stall_count(stall_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_ex_rs = '0; id_ex_rd = '0; id_ex_memRead = 1'b0;
        ex_mem_regWrite = 1'b0; ex_mem_rd = '0; mem_wb_regWrite = 1'b0; mem_wb_rd = '0;
        id_mdu = 1'b0; id_rd = '0;
    endtask

    // Compare every DUT output against the model for the current cycle, then
    // advance the model across the coming clock edge.
    task automatic model_check();
        int rs_id[NUM_SRC];
        int rs_ex;
        logic [NUM_SRC*2-1:0] efwd;
        bit busy, pending, lu, raw, st, est;
        int max16, max4;
        max16 = (1 << CNT_W) - 1;
        max4  = (1 << CNT4_W) - 1;
        if (!rst_n) begin
            m_valid = 0; m_cnt = 0; m_cnt4 = 0;
            chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
            chk("rst_stall_count", 32'(stall_count), 32'd0);
            chk("rst_stall_count4", 32'(stall_count4), 32'd0);
            return;
        end
        efwd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_id[i] = int'(id_rs[i*REG_AW +: REG_AW]);
            rs_ex    = int'(id_ex_rs[i*REG_AW +: REG_AW]);
            if (rs_ex != 0 && ex_mem_regWrite && int'(ex_mem_rd) == rs_ex)      efwd[i*2 +: 2] = 2'b10;
            else if (rs_ex != 0 && mem_wb_regWrite && int'(mem_wb_rd) == rs_ex) efwd[i*2 +: 2] = 2'b01;
        end
        busy    = m_valid && (cyc <= m_issue + MDU_LAT);
        pending = m_valid && (cyc <  m_issue + MDU_LAT);
        lu = 0; raw = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_ex_memRead && id_ex_rd != 0 && rs_id[i] == int'(id_ex_rd)) lu = 1;
            if (pending && m_rd != 0 && rs_id[i] == m_rd) raw = 1;
        end
        st  = pending && id_mdu;
        est = lu || raw || st;
        chk("forward", 32'(forward), 32'(efwd));
        chk("stall", 32'(stall), 32'(est));
        chk("bubble", 32'(bubble), 32'(est));
        chk("mdu_busy", 32'(mdu_busy), 32'(busy));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        chk("stall_count4", 32'(stall_count4), 32'(m_cnt4));
        if (id_mdu && !est) begin
            m_valid = 1; m_issue = cyc; m_rd = int'(id_rd);
        end
        if (est) begin
            if (m_cnt  < max16) m_cnt++;
            if (m_cnt4 < max4)  m_cnt4++;
        end
        cyc++;
    endtask

    // One clock cycle: check at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0; m_valid = 0; m_issue = 0; m_rd = 0; m_cnt = 0; m_cnt4 = 0;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("lit_reset_busy", 32'(mdu_busy), 32'd0);
        chk("lit_reset_count", 32'(stall_count), 32'd0);
        chk("lit_reset_stall", 32'(stall), 32'd0);
        chk("lit_reset_fwd", 32'(forward), 32'd0);
        do_reset();

        // Forwarding priority
        id_ex_rs = {5'd2, 5'd1};
        ex_mem_regWrite = 1'b1; ex_mem_rd = 5'd1;
        mem_wb_regWrite = 1'b1; mem_wb_rd = 5'd2;
        #1 chk("lit_fwd_mix", 32'(forward), 32'h6);
        mem_wb_rd = 5'd1;
        #1 chk("lit_fwd_exmem_wins", 32'(forward), 32'h2);
        id_ex_rs = {5'd1, 5'd1}; ex_mem_rd = 5'd0;
        #1 chk("lit_fwd_memwb_both", 32'(forward), 32'h5);
        id_ex_rs = '0; mem_wb_rd = 5'd0;
        #1 chk("lit_fwd_x0", 32'(forward), 32'h0);
        step();
        clear_inputs();

        // Load-use: one-cycle stall, counted once
        id_ex_memRead = 1'b1; id_ex_rd = 5'd5; id_rs = {5'd5, 5'd0};
        #1 chk("lit_lu_stall", 32'(stall), 32'd1);
        chk("lit_lu_bubble", 32'(bubble), 32'd1);
        step();
        clear_inputs();
        #1 chk("lit_lu_count", 32'(stall_count), 32'd1);
        chk("lit_lu_released", 32'(stall), 32'd0);
        id_ex_memRead = 1'b1; id_ex_rd = 5'd0; id_rs = {5'd0, 5'd0};
        #1 chk("lit_lu_x0", 32'(stall), 32'd0);
        step();
        clear_inputs();

        // MDU RAW: consumer of x7 waits MDU_LAT-1 cycles
        id_mdu = 1'b1; id_rd = 5'd7;
        #1 chk("lit_mdu_issue_nostall", 32'(stall), 32'd0);
        step();
        id_mdu = 1'b0; id_rd = '0; id_rs = {5'd0, 5'd7};
        for (int k = 0; k < MDU_LAT - 1; k++) begin
            #1 chk("lit_raw_stall", 32'(stall), 32'd1);
            step();
        end
        chk("lit_raw_release", 32'(stall), 32'd0);
        chk("lit_raw_busy_completion", 32'(mdu_busy), 32'd1);
        step();
        chk("lit_raw_idle", 32'(mdu_busy), 32'd0);
        clear_inputs();

        // Back-to-back MDU: second op waits, issues in the completion cycle
        id_mdu = 1'b1; id_rd = 5'd7;
        step();
        id_rd = 5'd9; id_rs = {5'd3, 5'd4};
        for (int k = 0; k < MDU_LAT - 1; k++) begin
            #1 chk("lit_struct_stall", 32'(stall), 32'd1);
            chk("lit_struct_busy", 32'(mdu_busy), 32'd1);
            step();
        end
        chk("lit_struct_issue", 32'(stall), 32'd0);
        chk("lit_struct_busy_c", 32'(mdu_busy), 32'd1);
        step();
        clear_inputs();
        #1 chk("lit_struct_busy_after", 32'(mdu_busy), 32'd1);
        for (int k = 0; k < MDU_LAT; k++) step();

        // Asynchronous reset mid-operation
        id_mdu = 1'b1; id_rd = 5'd7;
        step();
        id_mdu = 1'b0; id_rd = '0; id_rs = {5'd7, 5'd0};
        step();
        #1 chk("lit_pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1 chk("lit_async_busy", 32'(mdu_busy), 32'd0);
        chk("lit_async_count", 32'(stall_count), 32'd0);
        chk("lit_async_nostall", 32'(stall), 32'd0);
        step();
        rst_n = 1'b1;
        clear_inputs();

        // Saturation of the narrow counter
        id_ex_memRead = 1'b1; id_ex_rd = 5'd5; id_rs = {5'd5, 5'd0};
        for (int k = 0; k < 20; k++) step();
        chk("lit_sat4", 32'(stall_count4), 32'd15);
        chk("lit_count16", 32'(stall_count), 32'd20);
        clear_inputs();

        // Randomized traffic on a small register window to provoke matches
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                id_rs[i*REG_AW +: REG_AW]    = REG_AW'($urandom_range(0, 7));
                id_ex_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            end
            id_ex_rd        = REG_AW'($urandom_range(0, 7));
            id_ex_memRead   = ($urandom_range(0, 2) == 0);
            ex_mem_regWrite = $urandom_range(0, 1) == 1;
            ex_mem_rd       = REG_AW'($urandom_range(0, 7));
            mem_wb_regWrite = $urandom_range(0, 1) == 1;
            mem_wb_rd       = REG_AW'($urandom_range(0, 7));
            id_mdu          = ($urandom_range(0, 3) == 0);
            id_rd           = REG_AW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the risc_v_top pipeline. It generalises operand forwarding to NUM_SRC source operands and adds three things:
- load-use stall detection;
- a scoreboard for one in-flight multi-cycle (MDU) operation of fixed latency;
- a saturating stall-cycle performance counter.

It sits beside the ID/EX and EX stages. It drives the EX operand muxes, the PC/IF-ID hold and the ID/EX bubble insert.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (1..4)
- MDU_LAT, 4, MDU result latency in cycles from issue (2..16)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs  in  NUM_SRC*REG_AW  sources of instruction in ID (src i at [i*REG_AW +: REG_AW])
- id_ex_rs  in  NUM_SRC*REG_AW  sources of instruction in EX
- id_ex_rd  in  REG_AW  destination of instruction in EX
- id_ex_memRead  in  1  instruction in EX is a load
- ex_mem_regWrite  in  1  EX/MEM writes rd
- ex_mem_rd  in  REG_AW  EX/MEM destination
- mem_wb_regWrite  in  1  MEM/WB writes rd
- mem_wb_rd  in  REG_AW  MEM/WB destination
- id_mdu  in  1  instruction in ID is an MDU op
- id_rd  in  REG_AW  destination of instruction in ID
- forward  out  NUM_SRC*2  per-source mux select for EX operands
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX (always equals stall)
- mdu_busy  out  1  scoreboard entry valid
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- **Forwarding** (combinational, per source i, register x0 never matches):
  - 2'b10 if ex_mem_regWrite and ex_mem_rd==id_ex_rs[i];
  - else 2'b01 if mem_wb_regWrite and mem_wb_rd==id_ex_rs[i];
  - else 2'b00.
  - EX/MEM always wins over MEM/WB.
- **Load-use hazard**: id_ex_memRead, id_ex_rd!=0, and id_ex_rd equals any id_rs[i] → stall.
- **MDU RAW hazard**: mdu_busy, cnt!=0, sb_rd!=0, and sb_rd equals any id_rs[i] → stall.
- **MDU structural hazard**: id_mdu, mdu_busy and cnt!=0 → stall.
- stall is the OR of the three hazards; bubble = stall.
- **Scoreboard state**: sb_valid (= mdu_busy), sb_rd, cnt of width $clog2(MDU_LAT).
  - Issue = id_mdu && !stall. On issue: sb_valid←1, sb_rd←id_rd, cnt←MDU_LAT-1.
  - While valid and cnt!=0: cnt decrements each cycle.
  - Completion cycle (valid && cnt==0): the result is on the MEM/WB bus and is forwarded normally, so no stall. sb_valid←0 unless an issue occurs in the same cycle.
  - Issue in a completion cycle reloads the entry, so back-to-back MDU ops run with no gap.
- **stall_count** increments by 1 each cycle stall=1 and saturates at all-ones.

## Timing
- forward, stall and bubble are combinational from inputs and current state, with zero latency.
- State updates on the rising edge of clk.
- rst_n low asynchronously clears sb_valid, sb_rd, cnt and stall_count. Mid-operation this drops the in-flight MDU entry immediately.
- Outputs during and after reset:
  - mdu_busy=0, stall_count=0;
  - forward/stall/bubble = 0 when all inputs are 0.
- A load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM and the bubble is in EX.
- An MDU RAW stall lasts until the completion cycle, i.e. at most MDU_LAT-1 cycles after the issue cycle.
- The issue cycle itself can see a load-use stall; then no issue occurs and the state is unchanged.

## Structure
- Shared package `hazard_pkg`:
  - FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10;
  - a function returning 1 if a reg address is non-zero and matches.
- Sub-module `fwd_select`: one-source priority comparator producing a 2-bit select, instantiated NUM_SRC times in a generate loop.
- Scoreboard, hazard OR and counter stay in the top module.

## Test plan
- id_ex_rs={x2,x1}, ex_mem_rd=x1 (regWrite=1), mem_wb_rd=x1 and mem_wb_rd=x2 (regWrite=1) → forward={01,10}. With ex_mem_rd=x0 → forward={01,01}.
- Load with id_ex_rd=x5, memRead=1, id_rs[1]=x5 → stall=bubble=1 for one cycle, stall_count=1. With id_ex_rd=x0 → no stall.
- MDU_LAT=4, issue with id_rd=x7, then consumer of x7 in ID → stall for 3 cycles. Release in the completion cycle with mdu_busy=1, then mdu_busy=0.
- Second MDU op presented while cnt!=0 → stalls until the completion cycle, then issues. mdu_busy stays 1 continuously.
- Assert rst_n low during cnt=2 → mdu_busy=0 and stall_count=0 immediately, with no clock edge. Consumer of the old rd is not stalled.
- CNT_W=4 with 20 consecutive stall cycles → stall_count holds 15.
